// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a slow-memory FSM (IDLE -> BUSY x WAIT_CYCLES -> DONE).
// ready drops combinationally with a new request and returns only for the single DONE cycle.
module data_mem_responder #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic [1:0]            busy_state
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [WORD_WIDTH-1:0] read_data_q;

    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [WORD_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      in_idx;
    logic                  req;
    logic                  do_access;
    logic                  acc_wr;
    logic [IDX_W-1:0]      acc_idx;
    logic [WORD_WIDTH-1:0] acc_data;
    logic                  unused_addr_bits;

    // Subtracting the base then dropping byte bits makes out-of-range addresses wrap.
    assign offset           = address - WORD_WIDTH'(BASE_ADDR);
    assign in_idx           = offset[IDX_W+1:2];
    assign unused_addr_bits = ^{offset[1:0], offset[WORD_WIDTH-1:IDX_W+2]};
    assign req              = mem_read | mem_write;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        idx_d     = idx_q;
        data_d    = data_q;
        do_access = 1'b0;
        acc_wr    = op_wr_q;
        acc_idx   = idx_q;
        acc_data  = data_q;
        ready     = 1'b1;
        unique case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    op_wr_d = mem_write;
                    idx_d   = in_idx;
                    data_d  = write_data;
                    cnt_d   = CNT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the request edge itself.
                        state_d   = DONE;
                        do_access = 1'b1;
                        acc_wr    = mem_write;
                        acc_idx   = in_idx;
                        acc_data  = write_data;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                ready = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d   = DONE;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            if (do_access && !acc_wr) begin
                read_data_q <= mem[acc_idx];
            end
        end
    end

    // Array is deliberately not reset; rst only suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_wr) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign read_data  = read_data_q;
    assign busy_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one instance with 4 wait states, one with 0 wait states.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd4, wr4, rd0, wr0;
    logic [31:0] a4, d4, a0, d0;
    logic [31:0] q4, q0;
    logic        rdy4, rdy0;
    logic [1:0]  st4, st0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.WORD_WIDTH(32), .DEPTH_WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .mem_read(rd4), .mem_write(wr4), .address(a4),
        .write_data(d4), .read_data(q4), .ready(rdy4), .busy_state(st4)
    );

    data_mem_responder #(.WORD_WIDTH(32), .DEPTH_WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .address(a0),
        .write_data(d0), .read_data(q0), .ready(rdy0), .busy_state(st0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives a request just after a rising edge, counts ready-low cycles at negedges,
    // and returns read_data/state seen in the first ready-high (DONE) cycle.
    task automatic access(input bit w0, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lows, output logic [31:0] q,
                          output logic [1:0] st);
        if (w0) begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
        else    begin rd4 = rd; wr4 = wr; a4 = a; d4 = d; end
        lows = 0;
        @(negedge clk);
        while (((w0 ? rdy0 : rdy4) == 1'b0) && lows < 40) begin
            lows++;
            @(negedge clk);
        end
        q  = w0 ? q0 : q4;
        st = w0 ? st0 : st4;
        @(posedge clk);
        #1;
        if (w0) begin rd0 = 1'b0; wr0 = 1'b0; end
        else    begin rd4 = 1'b0; wr4 = 1'b0; end
    endtask

    initial begin
        int          lows;
        logic [31:0] q;
        logic [1:0]  st;

        rst = 1'b1;
        rd4 = 1'b0; wr4 = 1'b0; a4 = '0; d4 = '0;
        rd0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, rdy4}, 32'd1);
        chk("rst_rdata", q4, 32'd0);
        chk("rst_state", {30'd0, st4}, 32'd0);
        chk("rst_ready0", {31'd0, rdy0}, 32'd1);
        @(posedge clk);
        #1;

        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lows, q, st);
        chk("wr_lows", lows, 32'd5);
        chk("wr_done_state", {30'd0, st}, 32'd2);

        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, lows, q, st);
        chk("rd_lows", lows, 32'd5);
        chk("rd_data", q, 32'hDEADBEEF);
        chk("rd_done_state", {30'd0, st}, 32'd2);

        // index 64 wraps to word 0
        access(1'b0, 1'b0, 1'b1, 32'd1280, 32'h11, lows, q, st);
        chk("wrap_wr_rdata_held", q, 32'hDEADBEEF);
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, lows, q, st);
        chk("wrap_rd", q, 32'h11);
        access(1'b0, 1'b1, 1'b0, 32'd1027, 32'h0, lows, q, st);
        chk("unaligned_rd", q, 32'h11);

        access(1'b0, 1'b1, 1'b1, 32'd1028, 32'h55, lows, q, st);
        chk("rdwr_lows", lows, 32'd5);
        chk("rdwr_rdata_held", q, 32'h11);
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, lows, q, st);
        chk("rdwr_word1", q, 32'h55);

        // Abandoned write must leave the previous contents of word 2 intact.
        access(1'b0, 1'b0, 1'b1, 32'd1032, 32'hAAAA5555, lows, q, st);
        rd4 = 1'b0; wr4 = 1'b1; a4 = 32'd1032; d4 = 32'h77;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_busy_state", {30'd0, st4}, 32'd1);
        rst = 1'b1; wr4 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_state", {30'd0, st4}, 32'd0);
        chk("abort_ready", {31'd0, rdy4}, 32'd1);
        chk("abort_rdata", q4, 32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, lows, q, st);
        chk("abort_old_word", q, 32'hAAAA5555);

        access(1'b1, 1'b0, 1'b1, 32'd1044, 32'h1234, lows, q, st);
        chk("w0_wr_lows", lows, 32'd1);
        access(1'b1, 1'b0, 1'b1, 32'd1048, 32'h5678, lows, q, st);
        access(1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, lows, q, st);
        chk("w0_rdA_lows", lows, 32'd1);
        chk("w0_rdA_data", q, 32'h1234);
        chk("w0_rdA_state", {30'd0, st}, 32'd2);
        access(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, lows, q, st);
        chk("w0_rdB_lows", lows, 32'd1);
        chk("w0_rdB_data", q, 32'h5678);

        @(negedge clk);
        chk("final_idle_ready", {31'd0, rdy4}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the MEM stage's data-access requests, driven by the EXE-register outputs: mem_read, mem_write, ALU result as address, Rm value as store data.
- Holds a word-addressed data memory.
- Emulates a slow memory with a configurable number of wait states.
- Deasserts ready while an access is in flight so the pipeline can drive its freeze signals from ~ready.

Parameters:
WORD_WIDTH, 32, data and address width (matches `WORD_WIDTH).
DEPTH_WORDS, 64, number of memory words; power of two.
BASE_ADDR, 1024, byte address mapped to word 0.
WAIT_CYCLES, 4, BUSY cycles per access; range 0..15.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
mem_read  input  1  load request.
mem_write  input  1  store request.
address  input  WORD_WIDTH  byte address (ALU result).
write_data  input  WORD_WIDTH  store data (Rm value).
read_data  output  WORD_WIDTH  registered load result.
ready  output  1  high = no access pending; low = requester must freeze.
busy_state  output  2  current FSM state for debug: 0=IDLE, 1=BUSY, 2=DONE.

Behaviour:
- Reset: on an rst-high clock edge, state=IDLE, counter=0, read_data=0, latched address/data/op cleared. The memory array is NOT cleared.
- Reset during BUSY or DONE: the pending access is abandoned and no write occurs.
- Index calculation: index = ((address - BASE_ADDR) >> 2) mod DEPTH_WORDS.
  - address[1:0] is ignored.
  - Out-of-range addresses wrap through the low index bits; no error is raised.
- ready is combinational:
  - IDLE: ready = ~(mem_read | mem_write), so a new request drops ready in the same cycle it appears.
  - BUSY: ready = 0.
  - DONE: ready = 1.
- IDLE state:
  - When mem_read or mem_write is high, latch the op, index and write_data.
  - Go to BUSY with counter = WAIT_CYCLES-1, or go directly to DONE if WAIT_CYCLES=0.
  - If mem_read and mem_write are both high, the access is a write; a read is not performed.
- BUSY state:
  - counter decrements each cycle.
  - On the edge where counter==0, go to DONE and perform the access:
    - Write: mem[index] <= latched data.
    - Read: read_data <= mem[index].
- DONE state: lasts exactly one cycle, with ready=1; the requester advances on this edge. The next state is IDLE unconditionally.
- Back-to-back requests: a request present in the IDLE cycle after DONE starts a new access. No combinational path exists from DONE to BUSY.
- Latency per access: the requester sees ready=0 for WAIT_CYCLES+1 cycles (request cycle plus BUSY cycles), then ready=1 for 1 cycle (DONE).
- read_data:
  - Updated only when a read completes.
  - Holds its value across writes and idle cycles.
  - Valid from the DONE cycle onward.
- Requester protocol:
  - address, write_data and op are held stable while ready=0.
  - Changing them mid-BUSY is a violation; the block completes using its latched values and ignores the changes.
- No request in IDLE: ready=1, state unchanged, memory unchanged.

Test Plan:
- Reset with rst=1 for 2 cycles, then idle inputs -> ready=1, read_data=0, busy_state=0.
- With WAIT_CYCLES=4: write 0xDEADBEEF to address 1024 -> ready low for 5 cycles, high in the DONE cycle; then read 1024 -> read_data=0xDEADBEEF in DONE, and ready low again for 5 cycles.
- Wrap and alignment with DEPTH_WORDS=64:
  - Write 0x11 to address 1024+256 (index 64 wraps to 0) -> read of 1024 returns 0x11.
  - Read of address 1027 also returns 0x11 (low bits ignored).
- mem_read=mem_write=1 with address 1028, data 0x55 -> word 1 becomes 0x55; read_data keeps its previous value.
- Assert rst for 1 cycle mid-BUSY of a write of 0x77 to 1032 -> state IDLE and ready=1 next cycle; a following read of 1032 returns the old contents, not 0x77.
- WAIT_CYCLES=0: two back-to-back reads -> each read shows ready=0 for 1 cycle then ready=1 for 1 cycle; correct read_data returned for both.
